// File: rtl/dbg_bvci_txn_tracker.sv
// ----------------------------------------------------------------------------
// dbg_bvci_txn_tracker
//
// Purpose:
//   Single-outstanding BVCI transaction tracker. It sits between the debug
//   JTAG command buffer (upstream) and the debug module's BVCI target port
//   (downstream). The buffer's one-cycle command pulse is captured and held
//   on the target port until it is accepted. The tracker then waits for the
//   target response and holds it upstream until it is acknowledged. Only one
//   transaction is in flight at a time. A command pulse that arrives while a
//   transaction is in flight is dropped and flagged.
//
// Optional feature (compile-time macro DBG_TRK_WATCHDOG_EN):
//   When defined, a watchdog counts cycles spent in CMD/WAIT. On reaching
//   TMO_CYCLES it synthesizes an error response (rdata=0, reop=1, rerr=1),
//   so the upstream stall always releases. If the target had already
//   accepted the command, its late response is absorbed in FLUSH after the
//   error response has been acknowledged. When the macro is undefined, CMD
//   and WAIT wait indefinitely, FLUSH does not exist and trk_tmo is 0.
//
// Parameters:
//   TMO_CYCLES      watchdog limit in clk cycles (2..65535), default 1024
//
// Ports:
//   clk, rst_a      clock, asynchronous active-high reset
//   up_dbg_*        command in / response out, buffer side
//   dm_dbg_*        command out / response in, target side
//   trk_drop        one-cycle pulse: command arrived while busy
//   trk_tmo         one-cycle pulse: watchdog fired
// ----------------------------------------------------------------------------
module dbg_bvci_txn_tracker #(
    parameter int TMO_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_a,

    input  logic [31:0] up_dbg_address,
    input  logic [3:0]  up_dbg_be,
    input  logic [1:0]  up_dbg_cmd,
    input  logic [31:0] up_dbg_wdata,
    input  logic        up_dbg_eop,
    input  logic        up_dbg_cmdval,
    input  logic        up_dbg_rspack,
    output logic        up_dbg_rspval,
    output logic [31:0] up_dbg_rdata,
    output logic        up_dbg_reop,
    output logic        up_dbg_rerr,

    output logic [31:0] dm_dbg_address,
    output logic [3:0]  dm_dbg_be,
    output logic [1:0]  dm_dbg_cmd,
    output logic [31:0] dm_dbg_wdata,
    output logic        dm_dbg_eop,
    output logic        dm_dbg_cmdval,
    input  logic        dm_dbg_cmdack,
    input  logic        dm_dbg_rspval,
    input  logic [31:0] dm_dbg_rdata,
    input  logic        dm_dbg_reop,
    input  logic        dm_dbg_rerr,
    output logic        dm_dbg_rspack,

    output logic        trk_drop,
    output logic        trk_tmo
);

    // The limit is only meaningful in the watchdog build, but an out-of-range
    // value is rejected in every build so a bad configuration is caught early.
    if (TMO_CYCLES < 2 || TMO_CYCLES > 65535) begin : g_tmo_range_check
        $error("dbg_bvci_txn_tracker: TMO_CYCLES must be in 2..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_RSP
`ifdef DBG_TRK_WATCHDOG_EN
        , ST_FLUSH
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    logic cmd_capture;
    logic rsp_capture;
    logic tmo_fire;
    logic tmo_hit;

`ifdef DBG_TRK_WATCHDOG_EN
    localparam int CNT_W = $clog2(TMO_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TMO_CYCLES);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             orphan_q;
    logic             trk_tmo_q;

    // The watchdog fires in the cycle whose increment would bring the count
    // to TMO_CYCLES. Using >= instead of == keeps it armed after an ack that
    // won the race at the limit, so WAIT can never stall forever.
    assign tmo_hit = ((state_q == ST_CMD) || (state_q == ST_WAIT))
                     && (tmo_cnt_q >= CNT_LAST);

    // Cycle counter: cleared as the command is captured, counts while the
    // transaction is pending on the target, saturates at the limit.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            tmo_cnt_q <= '0;
        end else if (cmd_capture) begin
            tmo_cnt_q <= '0;
        end else if (((state_q == ST_CMD) || (state_q == ST_WAIT))
                     && (tmo_cnt_q != CNT_MAX)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Orphan flag: the target owns an accepted command whose response is
    // still outstanding, so it must be drained in FLUSH after the error
    // response. A timeout in CMD leaves nothing to drain.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            orphan_q  <= 1'b0;
            trk_tmo_q <= 1'b0;
        end else begin
            trk_tmo_q <= tmo_fire;
            if (tmo_fire && (state_q == ST_WAIT)) begin
                orphan_q <= 1'b1;
            end else if ((state_q == ST_RSP) && up_dbg_rspack) begin
                orphan_q <= 1'b0;
            end
        end
    end

    assign trk_tmo = trk_tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign trk_tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Target handshakes are checked before the watchdog so
    // an ack or response in the limit cycle wins over the timeout.
    always_comb begin
        state_d     = state_q;
        cmd_capture = 1'b0;
        rsp_capture = 1'b0;
        tmo_fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (up_dbg_cmdval) begin
                    cmd_capture = 1'b1;
                    state_d     = ST_CMD;
                end
            end
            ST_CMD: begin
                if (dm_dbg_cmdack) begin
                    state_d = ST_WAIT;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_d  = ST_RSP;
                end
            end
            ST_WAIT: begin
                if (dm_dbg_rspval) begin
                    rsp_capture = 1'b1;
                    state_d     = ST_RSP;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_d  = ST_RSP;
                end
            end
            ST_RSP: begin
                if (up_dbg_rspack) begin
`ifdef DBG_TRK_WATCHDOG_EN
                    state_d = orphan_q ? ST_FLUSH : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef DBG_TRK_WATCHDOG_EN
            ST_FLUSH: begin
                if (dm_dbg_rspval && dm_dbg_reop) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs. Handshake outputs are decoded from the next state
    // so they line up with the state register and have no combinational
    // path from any input. Command and response fields load only on capture
    // so they stay stable while presented.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            dm_dbg_address <= '0;
            dm_dbg_be      <= '0;
            dm_dbg_cmd     <= '0;
            dm_dbg_wdata   <= '0;
            dm_dbg_eop     <= 1'b0;
            dm_dbg_cmdval  <= 1'b0;
            dm_dbg_rspack  <= 1'b0;
            up_dbg_rspval  <= 1'b0;
            up_dbg_rdata   <= '0;
            up_dbg_reop    <= 1'b0;
            up_dbg_rerr    <= 1'b0;
            trk_drop       <= 1'b0;
        end else begin
            if (cmd_capture) begin
                dm_dbg_address <= up_dbg_address;
                dm_dbg_be      <= up_dbg_be;
                dm_dbg_cmd     <= up_dbg_cmd;
                dm_dbg_wdata   <= up_dbg_wdata;
                dm_dbg_eop     <= up_dbg_eop;
            end

            if (rsp_capture) begin
                up_dbg_rdata <= dm_dbg_rdata;
                up_dbg_reop  <= dm_dbg_reop;
                up_dbg_rerr  <= dm_dbg_rerr;
            end else if (tmo_fire) begin
                up_dbg_rdata <= 32'h0;
                up_dbg_reop  <= 1'b1;
                up_dbg_rerr  <= 1'b1;
            end

            dm_dbg_cmdval <= (state_d == ST_CMD);
`ifdef DBG_TRK_WATCHDOG_EN
            dm_dbg_rspack <= (state_d == ST_WAIT) || (state_d == ST_FLUSH);
`else
            dm_dbg_rspack <= (state_d == ST_WAIT);
`endif
            up_dbg_rspval <= (state_d == ST_RSP);
            trk_drop      <= up_dbg_cmdval && (state_q != ST_IDLE);
        end
    end

endmodule
